// File: rtl/config_pkg.sv
`default_nettype none
// ============================================================================
// Package     : config_pkg
// Description : Elaborated core configuration consumed by the PMA region
//               scanner. Carries the physical address width and the cached,
//               non-idempotent and execute region rule tables.
//               cva6_cfg_empty describes a core with no region rules.
// Revision    : 1.0 - initial release
// ============================================================================
package config_pkg;

  localparam int unsigned NrMaxRules = 16;

  typedef struct packed {
    int unsigned                        PLEN;
    int unsigned                        NrCachedRegionRules;
    logic [NrMaxRules-1:0][63:0]        CachedRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]        CachedRegionLength;
    int unsigned                        NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0]        NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0]        NonIdempotentLength;
    int unsigned                        NrExecuteRegionRules;
    logic [NrMaxRules-1:0][63:0]        ExecuteRegionAddrBase;
    logic [NrMaxRules-1:0][63:0]        ExecuteRegionLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    PLEN                  : 32'd56,
    NrCachedRegionRules   : 32'd0,
    CachedRegionAddrBase  : '0,
    CachedRegionLength    : '0,
    NrNonIdempotentRules  : 32'd0,
    NonIdempotentAddrBase : '0,
    NonIdempotentLength   : '0,
    NrExecuteRegionRules  : 32'd0,
    ExecuteRegionAddrBase : '0,
    ExecuteRegionLength   : '0
  };

endpackage
`default_nettype wire

// File: rtl/pma_region_scanner_if.sv
`default_nettype none
// ============================================================================
// Interface   : pma_region_scanner_if
// Description : Request/response bundle between a requester (master) and the
//               PMA region scanner (slave).
//   flush_i       master->slave  abort in-flight lookup
//   req_valid_i   master->slave  request valid
//   req_addr_i    master->slave  physical address (PLEN bits)
//   req_ready_o   slave->master  scanner can accept a request
//   rsp_valid_o   slave->master  result valid
//   rsp_ready_i   master->slave  requester accepts result
//   rsp_cached_o  slave->master  address hits a cached region
//   rsp_nonidem_o slave->master  address hits a non-idempotent region
//   rsp_exec_o    slave->master  address hits an execute region
// Revision    : 1.0 - initial release
// ============================================================================
interface pma_region_scanner_if #(
  parameter int unsigned PLEN = 56
);
  logic            flush_i;
  logic            req_valid_i;
  logic            req_ready_o;
  logic [PLEN-1:0] req_addr_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic            rsp_cached_o;
  logic            rsp_nonidem_o;
  logic            rsp_exec_o;

  modport master (
    output flush_i, req_valid_i, req_addr_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_cached_o, rsp_nonidem_o, rsp_exec_o
  );

  modport slave (
    input  flush_i, req_valid_i, req_addr_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_cached_o, rsp_nonidem_o, rsp_exec_o
  );
endinterface
`default_nettype wire

// File: rtl/pma_region_scanner.sv
`default_nettype none
// ============================================================================
// Module      : pma_region_scanner
// Description : Sequential physical-memory-attribute classifier. A latched
//               address is compared against one rule index of each region
//               table per cycle (cached, non-idempotent, execute), and the
//               per-table hits are OR-accumulated into three flags.
//   clk_i   : clock, all state updates on the rising edge
//   rst_ni  : synchronous active-low reset
//   bus     : pma_region_scanner_if slave modport (request/response)
// Revision    : 1.0 - initial release
// ============================================================================
module pma_region_scanner #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  pma_region_scanner_if.slave bus
);

  localparam int unsigned PLEN   = CVA6Cfg.PLEN;
  localparam int unsigned IdxW   = $clog2(config_pkg::NrMaxRules);
  localparam int unsigned NrC    = CVA6Cfg.NrCachedRegionRules;
  localparam int unsigned NrN    = CVA6Cfg.NrNonIdempotentRules;
  localparam int unsigned NrE    = CVA6Cfg.NrExecuteRegionRules;
  localparam int unsigned MaxCN  = (NrC > NrN) ? NrC : NrN;
  localparam int unsigned MaxCNE = (MaxCN > NrE) ? MaxCN : NrE;
  // Even with every table empty the scan still takes one cycle.
  localparam int unsigned ScanLen = (MaxCNE > 1) ? MaxCNE : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(ScanLen - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [IdxW-1:0] idx;
  logic [PLEN-1:0] addr_q;
  logic            cached_q;
  logic            nonidem_q;
  logic            exec_q;
  logic            ready_q;
  logic            valid_q;

  // The end bound is formed in 65 bits so a region ending exactly at 2^64
  // does not wrap to zero and is still matched.
  function automatic logic region_hit(input logic [63:0] base,
                                      input logic [63:0] len,
                                      input logic [63:0] addr);
    logic [64:0] region_end;
    region_end = {1'b0, base} + {1'b0, len};
    return (len != 64'd0) && (base <= addr) && ({1'b0, addr} < region_end);
  endfunction

  logic [63:0] addr_ext;
  logic        hit_cached;
  logic        hit_nonidem;
  logic        hit_exec;

  assign addr_ext = 64'(addr_q);

  // A table only contributes while idx is inside its own rule count, so
  // shorter tables simply drop out once the scan passes their last rule.
  assign hit_cached  = (32'(idx) < NrC) &&
                       region_hit(CVA6Cfg.CachedRegionAddrBase[idx],
                                  CVA6Cfg.CachedRegionLength[idx], addr_ext);
  assign hit_nonidem = (32'(idx) < NrN) &&
                       region_hit(CVA6Cfg.NonIdempotentAddrBase[idx],
                                  CVA6Cfg.NonIdempotentLength[idx], addr_ext);
  assign hit_exec    = (32'(idx) < NrE) &&
                       region_hit(CVA6Cfg.ExecuteRegionAddrBase[idx],
                                  CVA6Cfg.ExecuteRegionLength[idx], addr_ext);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      idx       <= '0;
      addr_q    <= '0;
      cached_q  <= 1'b0;
      nonidem_q <= 1'b0;
      exec_q    <= 1'b0;
      ready_q   <= 1'b1;
      valid_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // Flush wins over a request presented in the same cycle.
          if (!bus.flush_i && bus.req_valid_i) begin
            addr_q    <= bus.req_addr_i;
            idx       <= '0;
            cached_q  <= 1'b0;
            nonidem_q <= 1'b0;
            exec_q    <= 1'b0;
            ready_q   <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (bus.flush_i) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end else begin
            cached_q  <= cached_q  | hit_cached;
            nonidem_q <= nonidem_q | hit_nonidem;
            exec_q    <= exec_q    | hit_exec;
            if (idx == LastIdx) begin
              valid_q <= 1'b1;
              state   <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          // Returning to IDLE here (rather than accepting directly) keeps a
          // new request from overlapping the response handshake.
          if (bus.flush_i || bus.rsp_ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.rsp_valid_o   = valid_q;
  assign bus.rsp_cached_o  = cached_q;
  assign bus.rsp_nonidem_o = nonidem_q;
  assign bus.rsp_exec_o    = exec_q;

endmodule
`default_nettype wire

// File: tb/tb_pma_region_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_pma_region_scanner
// Description : Self-checking bench for pma_region_scanner with a two-entry
//               execute table and single-entry cached / non-idempotent tables
//               (ScanLen = 2). Table of addresses with hand-computed flags plus
//               backpressure, flush and mid-scan reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pma_region_scanner;

  function automatic config_pkg::cva6_cfg_t build_cfg();
    config_pkg::cva6_cfg_t c;
    c = config_pkg::cva6_cfg_empty;
    c.PLEN                     = 32;
    c.NrCachedRegionRules      = 1;
    c.CachedRegionAddrBase[0]  = 64'h8000_0000;
    c.CachedRegionLength[0]    = 64'h4000_0000;
    c.NrNonIdempotentRules     = 1;
    c.NonIdempotentAddrBase[0] = 64'h0;
    c.NonIdempotentLength[0]   = 64'h8000_0000;
    c.NrExecuteRegionRules     = 2;
    c.ExecuteRegionAddrBase[0] = 64'h0;
    c.ExecuteRegionLength[0]   = 64'h1000;
    c.ExecuteRegionAddrBase[1] = 64'h8000_0000;
    c.ExecuteRegionLength[1]   = 64'h4000_0000;
    return c;
  endfunction

  localparam config_pkg::cva6_cfg_t TbCfg = build_cfg();

  logic clk_i;
  logic rst_ni;

  pma_region_scanner_if #(.PLEN(32)) bus_if ();

  pma_region_scanner #(.CVA6Cfg(TbCfg)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [2:0]  flags;   // {cached, nonidem, exec}
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [2:0] flags_now();
    return {bus_if.rsp_cached_o, bus_if.rsp_nonidem_o, bus_if.rsp_exec_o};
  endfunction

  // Presents a request and returns once it has been accepted (one edge
  // after it was seen with req_ready high).
  task automatic issue(input string name, input logic [31:0] addr);
    int n;
    n = 0;
    while (!bus_if.req_ready_o && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({name, "_ready_timeout"}, 0, 1);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = addr;
    tick();
    bus_if.req_valid_i = 1'b0;
  endtask

  // Waits (bounded) for rsp_valid; returns edges counted after acceptance.
  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!bus_if.rsp_valid_o && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) check({name, "_rsp_timeout"}, 0, 1);
  endtask

  task automatic full_request(input string name, input logic [31:0] addr,
                              input logic [2:0] exp_flags);
    int lat;
    issue(name, addr);
    check({name, "_ready_busy"}, 64'(bus_if.req_ready_o), 0);
    wait_rsp(name, lat);
    check({name, "_latency"}, 64'(lat), 2);
    check({name, "_flags"}, 64'(flags_now()), 64'(exp_flags));
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    check({name, "_valid_drop"}, 64'(bus_if.rsp_valid_o), 0);
    check({name, "_ready_back"}, 64'(bus_if.req_ready_o), 1);
  endtask

  initial begin
    int lat;
    logic saw_valid;

    vecs[0] = '{"cached_exec",   32'h8000_1000, 3'b101};
    vecs[1] = '{"low_exec",      32'h0000_0800, 3'b011};
    vecs[2] = '{"nonidem_top",   32'h7FFF_FFFF, 3'b010};
    vecs[3] = '{"cached_end",    32'hC000_0000, 3'b000};
    vecs[4] = '{"exec0_last",    32'h0000_0FFF, 3'b011};
    vecs[5] = '{"exec0_end",     32'h0000_1000, 3'b010};
    vecs[6] = '{"cached_base",   32'h8000_0000, 3'b101};
    vecs[7] = '{"cached_last",   32'hBFFF_FFFF, 3'b101};
    vecs[8] = '{"top_of_space",  32'hFFFF_FFFF, 3'b000};

    rst_ni             = 1'b0;
    bus_if.flush_i     = 1'b0;
    bus_if.req_valid_i = 1'b0;
    bus_if.req_addr_i  = '0;
    bus_if.rsp_ready_i = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick();
    check("rst_ready", 64'(bus_if.req_ready_o), 1);
    check("rst_valid", 64'(bus_if.rsp_valid_o), 0);
    check("rst_flags", 64'(flags_now()), 0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      full_request(vecs[i].name, vecs[i].addr, vecs[i].flags);
    end

    // Backpressure: response held, competing request must wait.
    issue("bp", 32'h8000_1000);
    wait_rsp("bp", lat);
    check("bp_latency", 64'(lat), 2);
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = 32'h0000_0800;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 64'(bus_if.rsp_valid_o), 1);
      check("bp_flags_hold", 64'(flags_now()), 64'(3'b101));
      check("bp_ready_low", 64'(bus_if.req_ready_o), 0);
      tick();
    end
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;
    check("bp_post_valid", 64'(bus_if.rsp_valid_o), 0);
    check("bp_post_ready", 64'(bus_if.req_ready_o), 1);
    tick();   // pending request accepted here
    bus_if.req_valid_i = 1'b0;
    check("bp_second_busy", 64'(bus_if.req_ready_o), 0);
    wait_rsp("bp2", lat);
    check("bp2_latency", 64'(lat), 2);
    check("bp2_flags", 64'(flags_now()), 64'(3'b011));
    bus_if.rsp_ready_i = 1'b1;
    tick();
    bus_if.rsp_ready_i = 1'b0;

    // Flush in the first SCAN cycle.
    issue("fl", 32'h8000_1000);
    bus_if.flush_i = 1'b1;
    tick();
    bus_if.flush_i = 1'b0;
    check("fl_ready", 64'(bus_if.req_ready_o), 1);
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_valid |= bus_if.rsp_valid_o;
      tick();
    end
    check("fl_no_rsp", 64'(saw_valid), 0);

    // Flush has priority over a request in IDLE.
    bus_if.flush_i     = 1'b1;
    bus_if.req_valid_i = 1'b1;
    bus_if.req_addr_i  = 32'h8000_1000;
    tick();
    bus_if.flush_i     = 1'b0;
    bus_if.req_valid_i = 1'b0;
    check("fl_idle_prio", 64'(bus_if.req_ready_o), 1);
    tick();
    check("fl_idle_no_rsp", 64'(bus_if.rsp_valid_o), 0);
    full_request("fl_after", 32'h7FFF_FFFF, 3'b010);

    // Reset pulsed in the second SCAN cycle.
    issue("rs", 32'h8000_1000);
    tick();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    check("rs_ready", 64'(bus_if.req_ready_o), 1);
    check("rs_valid", 64'(bus_if.rsp_valid_o), 0);
    check("rs_flags", 64'(flags_now()), 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      saw_valid |= bus_if.rsp_valid_o;
      tick();
    end
    check("rs_no_rsp", 64'(saw_valid), 0);
    full_request("rs_after", 32'h8000_1000, 3'b101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
